// File: rtl/i2si_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2si_pkg
//  Description : Shared definitions for the I2S-input receive path: sample
//                width and source-select encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2si_pkg;

    localparam int   I2SI_DATA_W = 32;

    // Source-select encoding shared by every i2si selector
    localparam logic SEL_CH0     = 1'b0;
    localparam logic SEL_CH1     = 1'b1;

endpackage : i2si_pkg
`default_nettype wire

// File: rtl/i2si_in_mux.sv
`default_nettype none
// ============================================================================
//  Module      : i2si_in_mux
//  Description : Registered 2:1 sample selector for the I2S-input receive
//                path. Forwards the selected data/strobe pair with one cycle
//                of latency, counts forwarded strobes (saturating) and keeps
//                a sticky flag for strobes seen on the unselected source.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2si_in_mux
    import i2si_pkg::*;
#(
    parameter int DATA_W = I2SI_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_0_data,
    input  logic              in_0_xfc,
    input  logic [DATA_W-1:0] in_1_data,
    input  logic              in_1_xfc,
    input  logic              sel,
    input  logic              clr_stat,
    output logic [DATA_W-1:0] mux_data,
    output logic              mux_xfc,
    output logic [CNT_W-1:0]  xfc_count,
    output logic              drop_flag
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] r_mux_data;
    logic              r_mux_xfc;
    logic [CNT_W-1:0]  r_xfc_count;
    logic              r_drop_flag;

    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_xfc;
    logic              w_unsel_xfc;
    logic              w_cnt_sat;

    // Route the selected source to the output register and pick out the
    // strobe of the source that is being ignored this cycle.
    always_comb begin
        w_sel_data  = in_0_data;
        w_sel_xfc   = in_0_xfc;
        w_unsel_xfc = in_1_xfc;
        if (sel == SEL_CH1) begin
            w_sel_data  = in_1_data;
            w_sel_xfc   = in_1_xfc;
            w_unsel_xfc = in_0_xfc;
        end
    end

    assign w_cnt_sat = (r_xfc_count == C_CNT_MAX);

    // Data path: data forwarded every cycle, qualified downstream by mux_xfc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mux_data <= '0;
            r_mux_xfc  <= 1'b0;
        end else begin
            r_mux_data <= w_sel_data;
            r_mux_xfc  <= w_sel_xfc;
        end
    end

    // Statistics: saturating strobe counter and sticky drop flag; a clear
    // request takes priority over any same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfc_count <= '0;
            r_drop_flag <= 1'b0;
        end else if (clr_stat) begin
            r_xfc_count <= '0;
            r_drop_flag <= 1'b0;
        end else begin
            if (w_sel_xfc && !w_cnt_sat) begin
                r_xfc_count <= r_xfc_count + 1'b1;
            end
            if (w_unsel_xfc) begin
                r_drop_flag <= 1'b1;
            end
        end
    end

    assign mux_data  = r_mux_data;
    assign mux_xfc   = r_mux_xfc;
    assign xfc_count = r_xfc_count;
    assign drop_flag = r_drop_flag;

endmodule : i2si_in_mux
`default_nettype wire

// File: tb/tb_i2si_in_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2si_in_mux
//  Description : Directed self-checking bench for i2si_in_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2si_in_mux;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_0_data;
    logic              in_0_xfc;
    logic [DATA_W-1:0] in_1_data;
    logic              in_1_xfc;
    logic              sel;
    logic              clr_stat;
    logic [DATA_W-1:0] mux_data;
    logic              mux_xfc;
    logic [CNT_W-1:0]  xfc_count;
    logic              drop_flag;

    int n_vec = 0;
    int n_err = 0;

    i2si_in_mux #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_0_data (in_0_data),
        .in_0_xfc  (in_0_xfc),
        .in_1_data (in_1_data),
        .in_1_xfc  (in_1_xfc),
        .sel       (sel),
        .clr_stat  (clr_stat),
        .mux_data  (mux_data),
        .mux_xfc   (mux_xfc),
        .xfc_count (xfc_count),
        .drop_flag (drop_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_data, input logic e_xfc,
                             input logic [31:0] e_cnt, input logic e_flag);
        check({tag, ".mux_data"},  mux_data,          e_data);
        check({tag, ".mux_xfc"},   {31'd0, mux_xfc},  {31'd0, e_xfc});
        check({tag, ".xfc_count"}, {16'd0, xfc_count}, e_cnt);
        check({tag, ".drop_flag"}, {31'd0, drop_flag}, {31'd0, e_flag});
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d0, input logic x0, input logic [31:0] d1,
                         input logic x1, input logic s, input logic clr);
        in_0_data = d0;
        in_0_xfc  = x0;
        in_1_data = d1;
        in_1_xfc  = x1;
        sel       = s;
        clr_stat  = clr;
    endtask

    initial begin
        rst = 1'b0;
        drive(32'd25, 1'b1, 32'd50, 1'b1, 1'b0, 1'b0);

        // Reset is asynchronous: outputs must be zero before any clock edge
        #1 rst = 1'b1;
        #1;
        check_all("rst_async", 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        tick();
        check_all("rst_held", 32'd0, 1'b0, 32'd0, 1'b0);

        // First valid output one cycle after release; both strobes active, sel=0
        rst = 1'b0;
        tick();
        check_all("rst_release", 32'd25, 1'b1, 32'd1, 1'b1);

        // Clear statistics with idle strobes
        drive(32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("clr_idle", 32'd0, 1'b0, 32'd0, 1'b0);

        // Both strobe, sel=1: forward in_1, count it, in_0 marks a drop
        drive(32'd25, 1'b1, 32'd50, 1'b1, 1'b1, 1'b0);
        tick();
        check_all("sel1_both", 32'd50, 1'b1, 32'd1, 1'b1);

        // sel=0, only in_0 strobes
        drive(32'd100, 1'b1, 32'd1000, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("sel0_x0", 32'd100, 1'b1, 32'd2, 1'b1);

        // sel=1, selected strobe low, unselected high: no count
        drive(32'd2048, 1'b1, 32'd4096, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("sel1_drop", 32'd4096, 1'b0, 32'd2, 1'b1);

        // Clear wins over simultaneous strobe and drop; datapath unaffected
        drive(32'd7, 1'b1, 32'd9, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("clr_vs_evt", 32'd7, 1'b1, 32'd0, 1'b0);

        // Saturation: preload 2^16-1 strobes from zero
        drive(32'd11, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) tick();
        check_all("preload", 32'd11, 1'b1, 32'hFFFF, 1'b0);
        tick();
        check_all("saturate", 32'd11, 1'b1, 32'hFFFF, 1'b0);

        // Clear with simultaneous strobe at saturation
        clr_stat = 1'b1;
        tick();
        check_all("clr_sat", 32'd11, 1'b1, 32'd0, 1'b0);
        clr_stat = 1'b0;

        // Toggle sel every cycle; output follows exactly one cycle later
        for (int i = 0; i < 8; i++) begin
            drive(2 * i + 1, 1'b1, 2 * i + 2, 1'b0, i[0], 1'b0);
            tick();
            check("toggle.mux_data", mux_data, i[0] ? 2 * i + 2 : 2 * i + 1);
            check("toggle.mux_xfc", {31'd0, mux_xfc}, {31'd0, ~i[0]});
        end
        // 4 selected strobes (even i) counted, 4 drops flagged
        check("toggle.xfc_count", {16'd0, xfc_count}, 32'd4);
        check("toggle.drop_flag", {31'd0, drop_flag}, 32'd1);

        // Reset mid-transfer, between clock edges: clears immediately
        drive(32'd77, 1'b1, 32'd88, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_all("rst_mid", 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        rst = 1'b0;
        check_all("rst_mid_held", 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        check_all("rst_mid_rel", 32'd88, 1'b1, 32'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_i2si_in_mux
`default_nettype wire

// File: doc/i2si_in_mux.md
Name: i2si_in_mux

Overview:
- Registered 2:1 selector in the I2S-input (i2si) receive path.
- Chooses between two 32-bit sample sources, each with a transfer-complete strobe (xfc), and forwards the chosen data/strobe pair downstream.
- Adds a 1-cycle output register, a forwarded-transfer counter and a sticky flag for strobes dropped on the unselected input, so firmware can confirm the source selection is consistent.

Parameters:
- DATA_W, 32, width of the data inputs and mux_data.
- CNT_W, 16, width of xfc_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_0_data  in  DATA_W  source 0 sample.
- in_0_xfc  in  1  source 0 transfer-complete strobe.
- in_1_data  in  DATA_W  source 1 sample.
- in_1_xfc  in  1  source 1 transfer-complete strobe.
- sel  in  1  source select: 0 selects in_0, 1 selects in_1.
- clr_stat  in  1  synchronous clear of xfc_count and drop_flag.
- mux_data  out  DATA_W  registered selected data.
- mux_xfc  out  1  registered selected strobe.
- xfc_count  out  CNT_W  number of strobes forwarded on mux_xfc.
- drop_flag  out  1  sticky: an unselected input strobed.

Behaviour:
- Reset: while rst=1, mux_data=0, mux_xfc=0, xfc_count=0, drop_flag=0, regardless of clk.
- Data path, every cycle with rst=0:
  - mux_data <= sel ? in_1_data : in_0_data.
  - mux_xfc <= sel ? in_1_xfc : in_0_xfc.
- Latency: exactly 1 cycle from input sampling to output.
- Data is forwarded regardless of xfc. The downstream block qualifies data with mux_xfc.
- sel is sampled on the same edge as the data. A sel change takes effect on that edge with no blanking. Inputs are not held or buffered.
- xfc_count:
  - Increments by 1 on each cycle in which the selected xfc is 1.
  - Saturates at all-ones; it does not wrap.
- drop_flag is set on any cycle in which the unselected xfc is 1, for example sel=0 with in_1_xfc=1.
  - A simultaneous strobe on the selected input still forwards and still counts.
  - The flag stays set until clr_stat or rst.
- clr_stat=1:
  - Sets xfc_count to 0 and drop_flag to 0 on that edge.
  - If an increment or set event occurs in the same cycle, the clear wins; the event is lost.
  - Does not affect mux_data or mux_xfc.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously). The first valid output appears one cycle after rst deasserts.
- No handshake or backpressure: the downstream block must accept a mux_xfc pulse in the cycle it appears.

Decomposition:
- Shared i2si package holds:
  - I2SI_DATA_W = 32;
  - the select encoding constants SEL_CH0 = 0 and SEL_CH1 = 1.
- Single module; no sub-module needed. The statistics logic (counter plus sticky flag) may optionally be split into i2si_mux_stat if it is reused by other i2si selectors.

Test Plan:
- Reset: assert rst with inputs 25/50 and xfc=1, then release. Outputs read 0, 0, 0, 0 during reset; one cycle after release, mux_data=25 (sel=0).
- in_0=25, in_1=50, both xfc=1, sel=1 -> next cycle mux_data=50, mux_xfc=1, xfc_count=1, drop_flag=1 (in_0 strobed while unselected).
- in_0=100 xfc=1, in_1=1000 xfc=0, sel=0 -> next cycle mux_data=100, mux_xfc=1, xfc_count increments by 1.
- in_0=2048 xfc=1, in_1=4096 xfc=0, sel=1 -> next cycle mux_data=4096, mux_xfc=0, xfc_count unchanged, drop_flag=1.
- Preload 2^CNT_W-1 strobes, then one more with the selected xfc=1 -> xfc_count stays 0xFFFF. Then pulse clr_stat with a simultaneous strobe -> xfc_count=0, drop_flag=0.
- Toggle sel every cycle with distinct data (1, 2, 3, ...) -> mux_data tracks the selected input exactly one cycle later, with no glitch cycles.
